// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receive and transmit paths.
// No logic; consumed by uart_rx, uart_baud_counter and the future uart_tx.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE,
    PARITY_EVEN,
    PARITY_ODD
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;

  // Expected parity bit for a word; callers zero-extend, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [DATA_BITS_MAX-1:0] d, input parity_t p);
    return (p == PARITY_ODD) ? ~(^d) : ^d;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: tick on the last cycle of a full or half bit period, then wraps to 0.
// Latency: tick is combinational from the count; en=0 freezes the count and suppresses tick.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  input  logic half,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_TC = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);

  logic [CW-1:0] cnt;

  assign tick = en && !clear && (cnt == (half ? HALF_TC : FULL_TC));

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (en) begin
      if (clear || tick) cnt <= '0;
      else               cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of a pre-synchronized rx line into parallel words with error strobes.
// Strobes land CLKS_PER_BIT/2 + (DATA_BITS+P+1)*CLKS_PER_BIT edges after the start edge; no backpressure.
module uart_rx
  import uart_pkg::*;
#(
  parameter int      CLKS_PER_BIT = 16,
  parameter int      DATA_BITS    = 8,
  parameter parity_t PARITY       = PARITY_NONE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_clks_per_bit
    $error("uart_rx: CLKS_PER_BIT must be even and >= 4");
  end
  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
    $error("uart_rx: DATA_BITS out of range 5..9");
  end

  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  rx_state_t                state, state_nxt;
  logic                     tick, cnt_clear, cnt_half;
  logic [IW-1:0]            bit_idx;
  logic [DATA_BITS-1:0]     shreg;
  logic [DATA_BITS_MAX-1:0] shreg_ext;
  logic                     par_pend;

  assign shreg_ext = DATA_BITS_MAX'(shreg);
  assign busy      = (state != IDLE);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clear(cnt_clear),
    .half (cnt_half),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst)    state <= IDLE;
    else if (en) state <= state_nxt;
  end

  // Every bit state leaves on tick, which also wraps the counter, so each state starts from 0.
  always_comb begin
    state_nxt = state;
    cnt_clear = 1'b0;
    cnt_half  = 1'b0;
    case (state)
      IDLE: begin
        cnt_clear = 1'b1;
        if (!rx) state_nxt = START;
      end
      START: begin
        cnt_half = 1'b1;
        if (tick) state_nxt = rx ? IDLE : DATA;
      end
      DATA: begin
        if (tick && bit_idx == LAST_IDX)
          state_nxt = (PARITY == PARITY_NONE) ? STOP : uart_pkg::PARITY;
      end
      uart_pkg::PARITY: begin
        if (tick) state_nxt = STOP;
      end
      STOP: begin
        if (tick) state_nxt = rx ? IDLE : BREAK;
      end
      BREAK: begin
        cnt_clear = 1'b1;
        if (rx) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_idx    <= '0;
      shreg      <= '0;
      par_pend   <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (tick) begin
        case (state)
          START: begin
            bit_idx  <= '0;
            par_pend <= 1'b0;
          end
          DATA: begin
            // LSB arrives first, so shifting in from the top leaves it at bit 0.
            shreg   <= {rx, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + IW'(1);
          end
          uart_pkg::PARITY: begin
            par_pend <= (rx != parity_bit(shreg_ext, PARITY));
          end
          STOP: begin
            if (!rx) begin
              frame_err <= 1'b1;
            end else if (par_pend) begin
              parity_err <= 1'b1;
            end else begin
              data_out <= shreg;
              valid    <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
